// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles the I-fetch, D-access and memory-side signals of the memory port arbiter.
// Latency : n/a (signal bundle only).
// Backpress: memory stalls via m_ready; requesters hold req until their one-cycle ack.
// Ports    : slave = arbiter view (requests and m_ready/m_rdata in; acks, rdata, m_* out);
//            master = environment view (directions reversed).
interface mem_port_arbiter_if #(
    parameter int SIZE = 32,
    parameter int AW   = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [SIZE-1:0] i_rdata;
    logic            i_ack;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [SIZE-1:0] d_wdata;
    logic [SIZE-1:0] d_rdata;
    logic            d_ack;

    logic            err;

    logic            m_valid;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [SIZE-1:0] m_wdata;
    logic            m_ready;
    logic [SIZE-1:0] m_rdata;

    logic [1:0]      grant;
    logic            busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, err,
               m_valid, m_we, m_addr, m_wdata, grant, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, err,
               m_valid, m_we, m_addr, m_wdata, grant, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between the I-fetch and D-access requesters (round-robin on conflict).
// Latency : request sampled at E0 (m_valid from E0); m_ready at E1 -> ack in the cycle after E1; IDLE again at E2.
// Backpress: m_valid held until m_ready; aborted with err after TIMEOUT WAIT edges without m_ready.
// Ports    : clk, rst (sync, active-high); bus = mem_port_arbiter_if.slave carrying
//            i_req/i_addr/i_rdata/i_ack, d_req/d_we/d_addr/d_wdata/d_rdata/d_ack, err,
//            m_valid/m_we/m_addr/m_wdata/m_ready/m_rdata, grant, busy. All outputs registered.
module mem_port_arbiter #(
    parameter int SIZE    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter value at which a still-unanswered WAIT edge aborts the transaction.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;     // 1 = D owns the current transaction
    logic            last_q,  last_d;      // last conflict winner, 1 = D
    logic [7:0]      cnt_q,   cnt_d;
    logic            pick_d;

    logic            m_valid_q, m_valid_d;
    logic            m_we_q,    m_we_d;
    logic [AW-1:0]   m_addr_q,  m_addr_d;
    logic [SIZE-1:0] m_wdata_q, m_wdata_d;
    logic [1:0]      grant_q,   grant_d;
    logic            i_ack_q,   i_ack_d;
    logic            d_ack_q,   d_ack_d;
    logic            err_q,     err_d;
    logic [SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [SIZE-1:0] d_rdata_q, d_rdata_d;
    logic            busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= 8'd0;
            m_valid_q <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            grant_q   <= 2'b00;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            grant_q   <= grant_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        grant_d   = grant_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        // D wins when it is the only requester, or on a conflict when I won the last one.
        pick_d = bus.d_req & (~bus.i_req | ~last_q);

        case (state_q)
            S_IDLE: begin
                if (bus.i_req | bus.d_req) begin
                    if (bus.i_req & bus.d_req) begin
                        last_d = pick_d;
                    end
                    owner_d   = pick_d;
                    m_valid_d = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = S_WAIT;
                    if (pick_d) begin
                        m_we_d    = bus.d_we;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                        grant_d   = 2'b10;
                    end else begin
                        m_we_d    = 1'b0;
                        m_addr_d  = bus.i_addr;
                        m_wdata_d = '0;
                        grant_d   = 2'b01;
                    end
                end
            end

            S_WAIT: begin
                // m_ready takes priority over the abort on the final counted edge.
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    grant_d   = 2'b00;
                    state_d   = S_DONE;
                    if (owner_q) begin
                        d_ack_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = bus.m_rdata;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.m_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    m_valid_d = 1'b0;
                    grant_d   = 2'b00;
                    state_d   = S_DONE;
                    err_d     = 1'b1;
                    if (owner_q) begin
                        d_ack_d = 1'b1;
                    end else begin
                        i_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.grant   = grant_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.err     = err_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter against a transaction-level reference model.
// Latency : n/a.
// Backpress: bench plays the memory, choosing per transaction how many edges m_ready stays low.
module tb_mem_port_arbiter;

    localparam int SIZE    = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.SIZE(SIZE), .AW(AW)) bus ();

    mem_port_arbiter #(.SIZE(SIZE), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending requests, round-robin memory and expected rdata values.
    bit              i_pend, d_pend, d_w, last_was_d;
    logic [AW-1:0]   ia, da;
    logic [SIZE-1:0] dwd, exp_ir, exp_dr;
    logic [1:0]      seen_gnt;
    logic [SIZE-1:0] mem [logic [AW-1:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 7) * 4);
    endfunction

    function automatic int pick_k();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2));
        return int'($urandom_range(0, 4));
    endfunction

    task automatic drive_reqs();
        bus.i_req   = i_pend;
        bus.i_addr  = ia;
        bus.d_req   = d_pend;
        bus.d_we    = d_w;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
    endtask

    // mode 0: no new requests, 1: random new requests, 2: always refill idle requesters
    task automatic new_reqs(input int mode);
        if (mode != 0) begin
            if (!i_pend && (mode == 2 || $urandom_range(0, 1) == 1)) begin
                i_pend = 1'b1;
                ia     = rand_addr();
            end
            if (!d_pend && (mode == 2 || $urandom_range(0, 1) == 1)) begin
                d_pend = 1'b1;
                da     = rand_addr();
                d_w    = 1'($urandom_range(0, 1));
                dwd    = $urandom;
            end
        end
        drive_reqs();
    endtask

    // One full transaction from IDLE: k = edges with m_ready low before it rises; k >= TIMEOUT aborts.
    task automatic run_txn(input int k, input int mode);
        bit              wd, tmo;
        logic [AW-1:0]   ea;
        logic            ewe;
        logic [SIZE-1:0] ewd, rd;
        int              nw;

        if (i_pend && d_pend) begin
            wd         = !last_was_d;
            last_was_d = wd;
        end else begin
            wd = d_pend;
        end
        ea  = wd ? da : ia;
        ewe = wd ? d_w : 1'b0;
        ewd = wd ? dwd : '0;

        tick();
        seen_gnt = bus.grant;
        chk("grant",   bus.grant,   wd ? 2'b10 : 2'b01);
        chk("m_valid", bus.m_valid, 1'b1);
        chk("m_addr",  bus.m_addr,  ea);
        chk("m_we",    bus.m_we,    ewe);
        chk("m_wdata", bus.m_wdata, ewd);
        chk("busy",    bus.busy,    1'b1);
        chk("ack_early", {bus.i_ack, bus.d_ack}, 2'b00);

        // Winner occasionally drops its request while granted; the transaction must still finish.
        if ($urandom_range(0, 3) == 0) begin
            if (wd) begin
                bus.d_req  = 1'b0;
                bus.d_addr = AW'($urandom);
            end else begin
                bus.i_req  = 1'b0;
                bus.i_addr = AW'($urandom);
            end
        end

        tmo = (k >= TIMEOUT);
        nw  = tmo ? TIMEOUT - 1 : k;
        for (int c = 0; c < nw; c++) begin
            bus.m_ready = 1'b0;
            bus.m_rdata = $urandom;
            tick();
            chk("wait_vld",  bus.m_valid, 1'b1);
            chk("wait_addr", bus.m_addr,  ea);
        end

        rd = '0;
        bus.m_ready = !tmo;
        bus.m_rdata = $urandom;
        if (!tmo) begin
            if (ewe) begin
                mem[ea] = ewd;
            end else begin
                if (mem.exists(ea)) rd = mem[ea];
                else rd = $urandom;
                bus.m_rdata = rd;
            end
        end
        tick();

        if (!tmo && !ewe) begin
            if (wd) exp_dr = rd;
            else exp_ir = rd;
        end
        chk("done_iack",  bus.i_ack,   !wd);
        chk("done_dack",  bus.d_ack,   wd);
        chk("done_err",   bus.err,     tmo);
        chk("done_vld",   bus.m_valid, 1'b0);
        chk("done_grant", bus.grant,   2'b00);
        chk("i_rdata",    bus.i_rdata, exp_ir);
        chk("d_rdata",    bus.d_rdata, exp_dr);
        chk("done_busy",  bus.busy,    1'b1);

        if (wd) d_pend = 1'b0;
        else i_pend = 1'b0;

        // Ack cycle: stray m_ready and fresh requests must both be ignored here.
        bus.m_ready = 1'($urandom_range(0, 1));
        bus.m_rdata = $urandom;
        new_reqs(mode);
        tick();
        chk("idle_acks", {bus.i_ack, bus.d_ack}, 2'b00);
        chk("idle_err",  bus.err,     1'b0);
        chk("idle_busy", bus.busy,    1'b0);
        chk("idle_vld",  bus.m_valid, 1'b0);
        bus.m_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        bus.i_addr  = 32'h00400004;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h10010000;
        bus.d_wdata = 32'h12345678;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hA5A5A5A5;
        tick();
        tick();
        chk("rst_vld",   bus.m_valid, 1'b0);
        chk("rst_we",    bus.m_we,    1'b0);
        chk("rst_addr",  bus.m_addr,  '0);
        chk("rst_wdata", bus.m_wdata, '0);
        chk("rst_grant", bus.grant,   2'b00);
        chk("rst_iack",  bus.i_ack,   1'b0);
        chk("rst_dack",  bus.d_ack,   1'b0);
        chk("rst_err",   bus.err,     1'b0);
        chk("rst_irdat", bus.i_rdata, '0);
        chk("rst_drdat", bus.d_rdata, '0);
        chk("rst_busy",  bus.busy,    1'b0);

        last_was_d = 1'b0;
        exp_ir     = '0;
        exp_dr     = '0;
        mem[32'h00400004] = 32'h8C220004;

        // Persistent conflict: D write first, then I read, then two more alternating grants.
        i_pend = 1'b1; ia = 32'h00400004;
        d_pend = 1'b1; da = 32'h10010000; d_w = 1'b1; dwd = 32'hDEADBEEF;
        bus.m_ready = 1'b0;
        drive_reqs();
        rst = 1'b0;

        run_txn(0, 2);
        chk("order0", seen_gnt, 2'b10);
        chk("wr_drdata", bus.d_rdata, '0);
        run_txn(1, 2);
        chk("order1", seen_gnt, 2'b01);
        chk("rd_irdata", bus.i_rdata, 32'h8C220004);
        run_txn(int'($urandom_range(0, 3)), 2);
        chk("order2", seen_gnt, 2'b10);
        run_txn(int'($urandom_range(0, 3)), 2);
        chk("order3", seen_gnt, 2'b01);

        for (int n = 0; n < 80; n++) begin
            if (!i_pend && !d_pend) begin
                bus.m_ready = 1'($urandom_range(0, 1));
                tick();
                chk("idle_ready_ignored", bus.busy, 1'b0);
                bus.m_ready = 1'b0;
                new_reqs(1);
            end else begin
                run_txn(pick_k(), 1);
            end
        end
        for (int n = 0; n < 2; n++) begin
            if (i_pend || d_pend) run_txn(0, 0);
        end

        // Timeout on a D read, then a normal D read afterwards.
        d_pend = 1'b1; d_w = 1'b0; da = AW'(8);
        drive_reqs();
        run_txn(TIMEOUT + 4, 0);
        d_pend = 1'b1; d_w = 1'b0; da = AW'(8);
        drive_reqs();
        run_txn(2, 0);

        // Reset in the middle of an I read: no ack, and later m_ready is ignored.
        i_pend = 1'b1; ia = 32'h00400004;
        drive_reqs();
        tick();
        chk("rw_grant", bus.grant, 2'b01);
        bus.m_ready = 1'b0;
        tick();
        chk("rw_wait_vld", bus.m_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        i_pend      = 1'b0;
        bus.i_req   = 1'b0;
        bus.m_ready = 1'b1;
        bus.m_rdata = $urandom;
        last_was_d  = 1'b0;
        exp_ir      = '0;
        exp_dr      = '0;
        chk("rw_vld",    bus.m_valid, 1'b0);
        chk("rw_grant0", bus.grant,   2'b00);
        chk("rw_iack",   bus.i_ack,   1'b0);
        chk("rw_busy",   bus.busy,    1'b0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("rw_late_iack", bus.i_ack,   1'b0);
            chk("rw_late_busy", bus.busy,    1'b0);
            chk("rw_late_vld",  bus.m_valid, 1'b0);
        end
        bus.m_ready = 1'b0;

        // After reset the round-robin pointer is back at I, so D wins the first conflict.
        i_pend = 1'b1; ia = rand_addr();
        d_pend = 1'b1; da = rand_addr(); d_w = 1'b0; dwd = $urandom;
        drive_reqs();
        run_txn(1, 0);
        chk("post_rst_order", seen_gnt, 2'b10);
        run_txn(0, 0);
        chk("post_rst_order2", seen_gnt, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
